// File: rtl/fetch_decode_pkg.sv
// Shared constants for the fetch/decode stage: instruction codes, register IDs and instruction lengths.
package fetch_decode_pkg;

    typedef enum logic [3:0] {
        HALT   = 4'h0,
        NOP    = 4'h1,
        RRMOVQ = 4'h2,
        IRMOVQ = 4'h3,
        RMMOVQ = 4'h4,
        MRMOVQ = 4'h5,
        OPQ    = 4'h6,
        JXX    = 4'h7,
        CALL   = 4'h8,
        RET    = 4'h9,
        PUSHQ  = 4'hA,
        POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;
    localparam int         NUM_REGS = 15;

    // Instruction lengths in bytes, added to PC to form the fall-through address.
    localparam logic [63:0] LEN_BYTE = 64'd1;
    localparam logic [63:0] LEN_REG  = 64'd2;
    localparam logic [63:0] LEN_DEST = 64'd9;
    localparam logic [63:0] LEN_FULL = 64'd10;

    // True when an ID names a real register rather than "no register".
    function automatic logic is_reg_id(input logic [3:0] id);
        return id != RNONE;
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bus between the fetch/decode stage and its neighbours: instruction in, decoded fields out, write-back in.
interface fetch_decode_if;

    logic [63:0] PC;
    logic [0:79] instruction;

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        valid_instruction;
    logic        valid_memory;

    logic [3:0]  wb_dstE;
    logic [3:0]  wb_dstM;
    logic [63:0] wb_valE;
    logic [63:0] wb_valM;

    modport master (
        output PC, instruction, wb_dstE, wb_dstM, wb_valE, wb_valM,
        input  icode, ifun, rA, rB, valC, valP, valA, valB,
               srcA, srcB, dstE, dstM, valid_instruction, valid_memory
    );

    modport slave (
        input  PC, instruction, wb_dstE, wb_dstM, wb_valE, wb_valM,
        output icode, ifun, rA, rB, valC, valP, valA, valB,
               srcA, srcB, dstE, dstM, valid_instruction, valid_memory
    );

endinterface

// File: rtl/fetch_decode_regfile.sv
// Fifteen 64-bit registers, two combinational read ports, two write ports (M wins on a collision).
// With REGFILE_DEBUG_EN defined, the whole array is also exported for observation.
module regfile
    import fetch_decode_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   i_src_a,
    input  logic [3:0]                   i_src_b,
    output logic [63:0]                  o_val_a,
    output logic [63:0]                  o_val_b,
    input  logic [3:0]                   i_wb_dst_e,
    input  logic [63:0]                  i_wb_val_e,
    input  logic [3:0]                   i_wb_dst_m,
    input  logic [63:0]                  i_wb_val_m
`ifdef REGFILE_DEBUG_EN
    ,
    output logic [NUM_REGS-1:0][63:0]    o_regs
`endif
);

    logic [63:0] r_regs [NUM_REGS];

    // NOTE: this array is small enough to live in flops, so it is reset like any other state;
    // a large RAM-backed array would normally be left unreset.
    // NOTE: sequential state uses non-blocking assignments so every read in this edge sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // The M write is issued last so it overrides E when both target the same register.
            if (is_reg_id(i_wb_dst_e)) begin
                r_regs[i_wb_dst_e] <= i_wb_val_e;
            end
            if (is_reg_id(i_wb_dst_m)) begin
                r_regs[i_wb_dst_m] <= i_wb_val_m;
            end
        end
    end

    assign o_val_a = is_reg_id(i_src_a) ? r_regs[i_src_a] : '0;
    assign o_val_b = is_reg_id(i_src_b) ? r_regs[i_src_b] : '0;

`ifdef REGFILE_DEBUG_EN
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            o_regs[i] = r_regs[i];
        end
    end
`endif

endmodule

// File: rtl/fetch_decode.sv
// Combinational fetch/decode stage with a register file for operand reads.
// Build option REGFILE_DEBUG_EN adds register mirror outputs rax..r14.
module fetch_decode
    import fetch_decode_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_decode_if.slave bus
`ifdef REGFILE_DEBUG_EN
    ,
    output logic [63:0]   rax,
    output logic [63:0]   rcx,
    output logic [63:0]   rdx,
    output logic [63:0]   rbx,
    output logic [63:0]   rsp,
    output logic [63:0]   rbp,
    output logic [63:0]   rsi,
    output logic [63:0]   rdi,
    output logic [63:0]   r8,
    output logic [63:0]   r9,
    output logic [63:0]   r10,
    output logic [63:0]   r11,
    output logic [63:0]   r12,
    output logic [63:0]   r13,
    output logic [63:0]   r14
`endif
);

    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic [7:0]  w_byte1;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [63:0] w_valc;
    logic [63:0] w_len;
    logic [3:0]  w_src_a;
    logic [3:0]  w_src_b;
    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic [63:0] w_val_a;
    logic [63:0] w_val_b;

    // Bit 0 is the MSB of the first byte, so ascending slices read bytes in natural order.
    assign w_icode = bus.instruction[0:3];
    assign w_ifun  = bus.instruction[4:7];
    assign w_byte1 = bus.instruction[8:15];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_ra    = RNONE;
        w_rb    = RNONE;
        w_valc  = '0;
        w_len   = LEN_BYTE;
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (w_icode)
            RRMOVQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_len   = LEN_REG;
                w_src_a = w_ra;
                w_dst_e = w_rb;
            end
            IRMOVQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_valc  = bus.instruction[16:79];
                w_len   = LEN_FULL;
                w_dst_e = w_rb;
            end
            RMMOVQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_valc  = bus.instruction[16:79];
                w_len   = LEN_FULL;
                w_src_a = w_ra;
                w_src_b = w_rb;
            end
            MRMOVQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_valc  = bus.instruction[16:79];
                w_len   = LEN_FULL;
                w_src_b = w_rb;
                w_dst_m = w_ra;
            end
            OPQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_len   = LEN_REG;
                w_src_a = w_ra;
                w_src_b = w_rb;
                w_dst_e = w_rb;
            end
            JXX: begin
                w_valc  = bus.instruction[8:71];
                w_len   = LEN_DEST;
            end
            CALL: begin
                w_valc  = bus.instruction[8:71];
                w_len   = LEN_DEST;
                w_src_b = RSP;
                w_dst_e = RSP;
            end
            RET: begin
                w_src_a = RSP;
                w_src_b = RSP;
                w_dst_e = RSP;
            end
            PUSHQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_len   = LEN_REG;
                w_src_a = w_ra;
                w_src_b = RSP;
                w_dst_e = RSP;
            end
            POPQ: begin
                w_ra    = w_byte1[7:4];
                w_rb    = w_byte1[3:0];
                w_len   = LEN_REG;
                w_src_a = RSP;
                w_src_b = RSP;
                w_dst_e = RSP;
                w_dst_m = w_ra;
            end
            default: begin
                // HALT, NOP and undefined codes: one-byte instruction, no operands.
            end
        endcase
    end

`ifdef REGFILE_DEBUG_EN
    logic [NUM_REGS-1:0][63:0] w_regs;
`endif

    regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_src_a    (w_src_a),
        .i_src_b    (w_src_b),
        .o_val_a    (w_val_a),
        .o_val_b    (w_val_b),
        .i_wb_dst_e (bus.wb_dstE),
        .i_wb_val_e (bus.wb_valE),
        .i_wb_dst_m (bus.wb_dstM),
        .i_wb_val_m (bus.wb_valM)
`ifdef REGFILE_DEBUG_EN
        ,
        .o_regs     (w_regs)
`endif
    );

    assign bus.icode             = w_icode;
    assign bus.ifun              = w_ifun;
    assign bus.rA                = w_ra;
    assign bus.rB                = w_rb;
    assign bus.valC              = w_valc;
    assign bus.valP              = bus.PC + w_len;
    assign bus.valA              = w_val_a;
    assign bus.valB              = w_val_b;
    assign bus.srcA              = w_src_a;
    assign bus.srcB              = w_src_b;
    assign bus.dstE              = w_dst_e;
    assign bus.dstM              = w_dst_m;
    assign bus.valid_instruction = (w_icode <= POPQ);
    // Data memory spans the low 64 KiB only.
    assign bus.valid_memory      = (bus.PC[63:16] == '0);

`ifdef REGFILE_DEBUG_EN
    assign rax = w_regs[0];
    assign rcx = w_regs[1];
    assign rdx = w_regs[2];
    assign rbx = w_regs[3];
    assign rsp = w_regs[4];
    assign rbp = w_regs[5];
    assign rsi = w_regs[6];
    assign rdi = w_regs[7];
    assign r8  = w_regs[8];
    assign r9  = w_regs[9];
    assign r10 = w_regs[10];
    assign r11 = w_regs[11];
    assign r12 = w_regs[12];
    assign r13 = w_regs[13];
    assign r14 = w_regs[14];
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed cases plus random instructions checked
// against a table-driven decode model and an array model of the register file.
module tb_fetch_decode;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_decode_if bus();

`ifdef REGFILE_DEBUG_EN
    logic [63:0] dbg [15];
    fetch_decode u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rax(dbg[0]), .rcx(dbg[1]), .rdx(dbg[2]), .rbx(dbg[3]), .rsp(dbg[4]),
        .rbp(dbg[5]), .rsi(dbg[6]), .rdi(dbg[7]), .r8(dbg[8]), .r9(dbg[9]),
        .r10(dbg[10]), .r11(dbg[11]), .r12(dbg[12]), .r13(dbg[13]), .r14(dbg[14])
    );
`else
    fetch_decode u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int total = 0;
    int bad   = 0;

    logic [63:0] model [15];
    logic [7:0]  bytes [10];
    int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] reg_read(input logic [3:0] id);
        return (id == 4'hF) ? 64'd0 : model[id];
    endfunction

    task automatic load(input logic [63:0] pc, input logic [79:0] word);
        for (int k = 0; k < 10; k++) bytes[k] = word[79-8*k -: 8];
        bus.PC          = pc;
        bus.instruction = word;
    endtask

    task automatic load_bytes(input logic [63:0] pc);
        logic [79:0] word;
        for (int k = 0; k < 10; k++) word[79-8*k -: 8] = bytes[k];
        bus.PC          = pc;
        bus.instruction = word;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (bus.wb_dstE != 4'hF) model[bus.wb_dstE] = bus.wb_valE;
            if (bus.wb_dstM != 4'hF) model[bus.wb_dstM] = bus.wb_valM;
        end
        @(negedge clk);
    endtask

    task automatic wb_idle();
        bus.wb_dstE = 4'hF;
        bus.wb_dstM = 4'hF;
        bus.wb_valE = '0;
        bus.wb_valM = '0;
    endtask

    // Expected outputs derived directly from the instruction-set rules.
    task automatic check_all(input string tag);
        int          ic;
        logic [3:0]  ra, rb, sa, sb, de, dm;
        logic [63:0] vc;
        ic = int'(bytes[0][7:4]);
        ra = 4'hF;
        rb = 4'hF;
        if (ic inside {2, 3, 4, 5, 6, 10, 11}) begin
            ra = bytes[1][7:4];
            rb = bytes[1][3:0];
        end
        vc = '0;
        if (ic inside {3, 4, 5}) for (int k = 2; k <= 9; k++) vc = {vc[55:0], bytes[k]};
        if (ic inside {7, 8})    for (int k = 1; k <= 8; k++) vc = {vc[55:0], bytes[k]};
        sa = (ic inside {2, 4, 6, 10}) ? ra : (ic inside {9, 11}) ? 4'h4 : 4'hF;
        sb = (ic inside {4, 5, 6}) ? rb : (ic inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
        de = (ic inside {2, 3, 6}) ? rb : (ic inside {8, 9, 10, 11}) ? 4'h4 : 4'hF;
        dm = (ic inside {5, 11}) ? ra : 4'hF;
        check({tag, ".icode"}, 64'(bus.icode), 64'(bytes[0][7:4]));
        check({tag, ".ifun"},  64'(bus.ifun),  64'(bytes[0][3:0]));
        check({tag, ".rA"},    64'(bus.rA),    64'(ra));
        check({tag, ".rB"},    64'(bus.rB),    64'(rb));
        check({tag, ".valC"},  bus.valC, vc);
        check({tag, ".valP"},  bus.valP, bus.PC + 64'(len_tab[ic]));
        check({tag, ".srcA"},  64'(bus.srcA),  64'(sa));
        check({tag, ".srcB"},  64'(bus.srcB),  64'(sb));
        check({tag, ".dstE"},  64'(bus.dstE),  64'(de));
        check({tag, ".dstM"},  64'(bus.dstM),  64'(dm));
        check({tag, ".valA"},  bus.valA, reg_read(sa));
        check({tag, ".valB"},  bus.valB, reg_read(sb));
        check({tag, ".vi"},    64'(bus.valid_instruction), 64'(ic <= 11));
        check({tag, ".vm"},    64'(bus.valid_memory),      64'(bus.PC <= 64'd65535));
    endtask

    initial begin
        for (int r = 0; r < 15; r++) model[r] = '0;

        // Reset with live write-back traffic that must be ignored.
        rst_n       = 1'b0;
        bus.wb_dstE = 4'h2;
        bus.wb_valE = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.wb_dstM = 4'h3;
        bus.wb_valM = 64'h1111_2222_3333_4444;
        load(64'd64, 80'h2023_0000_0000_0000_0000);
        @(negedge clk);
        #1;
        check("reset.valA", bus.valA, 64'd0);
        tick();
        tick();
        #1;
        check("reset.valA_after_edges", bus.valA, 64'd0);
        wb_idle();
        rst_n = 1'b1;
        #1;
        check_all("r032");
        check("r032.icode", 64'(bus.icode), 64'd2);
        check("r032.rA", 64'(bus.rA), 64'd2);
        check("r032.rB", 64'(bus.rB), 64'd3);
        check("r032.valP", bus.valP, 64'd66);
        check("r032.vi", 64'(bus.valid_instruction), 64'd1);

        tick();
        load(64'd66, 80'h30F3_0000_0000_0000_001F);
        #1;
        check_all("r033");
        check("r033.valC", bus.valC, 64'd31);
        check("r033.dstE", 64'(bus.dstE), 64'd3);
        check("r033.valP", bus.valP, 64'd76);

        // Write rdx, reading it in the same cycle: old value until the edge.
        tick();
        load(64'd80, 80'h2023_0000_0000_0000_0000);
        bus.wb_dstE = 4'h2;
        bus.wb_valE = 64'h55;
        #1;
        check("r034.same_cycle_valA", bus.valA, 64'd0);
        tick();
        wb_idle();
        #1;
        check("r034.valA", bus.valA, 64'h55);
        check_all("r034");

        load(64'd98, 80'hA12F_0000_0000_0000_0000);
        #1;
        check_all("r035a");
        check("r035a.srcA", 64'(bus.srcA), 64'd2);
        check("r035a.srcB", 64'(bus.srcB), 64'd4);
        check("r035a.dstE", 64'(bus.dstE), 64'd4);
        check("r035a.valP", bus.valP, 64'd100);
        load(64'd98, 80'hB12F_0000_0000_0000_0000);
        #1;
        check_all("r035b");
        check("r035b.dstM", 64'(bus.dstM), 64'd2);
        check("r035b.srcA", 64'(bus.srcA), 64'd4);

        load(64'd500, 80'hC000_0000_0000_0000_0000);
        #1;
        check_all("r036a");
        check("r036a.vi", 64'(bus.valid_instruction), 64'd0);
        check("r036a.valP", bus.valP, 64'd501);
        load(64'd70000, 80'h1000_0000_0000_0000_0000);
        #1;
        check("r036b.vm", 64'(bus.valid_memory), 64'd0);
        load(64'd65535, 80'h1000_0000_0000_0000_0000);
        #1;
        check("r036c.vm_edge", 64'(bus.valid_memory), 64'd1);
        load(64'hFFFF_FFFF_FFFF_FFFE, 80'h3000_0000_0000_0000_0000);
        #1;
        check("wrap.valP", bus.valP, 64'd8);

        // Same register on both write ports: M must win.
        bus.wb_dstE = 4'h5;
        bus.wb_valE = 64'hEEEE;
        bus.wb_dstM = 4'h5;
        bus.wb_valM = 64'h4D4D;
        tick();
        wb_idle();
        load(64'd10, 80'h2050_0000_0000_0000_0000);
        #1;
        check("r037.m_wins", bus.valA, 64'h4D4D);
        check_all("r037a");

        // Random instructions with random write-back traffic.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 10; k++) bytes[k] = 8'($urandom);
            bytes[0][7:4] = 4'($urandom_range(0, 15));
            load_bytes(($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70000)));
            bus.wb_dstE = 4'($urandom_range(0, 15));
            bus.wb_dstM = ($urandom_range(0, 3) == 0) ? bus.wb_dstE : 4'($urandom_range(0, 15));
            bus.wb_valE = {$urandom, $urandom};
            bus.wb_valM = {$urandom, $urandom};
            #1;
            check_all($sformatf("rnd%0d", n));
            tick();
        end
        wb_idle();

        // Mid-run reset with a write pending.
        bus.wb_dstE = 4'h6;
        bus.wb_valE = 64'hDEAD;
        tick();
        load(64'd20, 80'h2060_0000_0000_0000_0000);
        bus.wb_dstE = 4'h6;
        bus.wb_valE = 64'hBEEF;
        #1;
        check("midrst.before", bus.valA, 64'hDEAD);
        #1;
        rst_n = 1'b0;
        for (int r = 0; r < 15; r++) model[r] = '0;
        #1;
        check("midrst.immediate", bus.valA, 64'd0);
        for (int r = 0; r < 15; r++) begin
            tick();
            load(64'd20, {8'h20, 4'(r), 4'h0, 64'h0});
            #1;
            check($sformatf("midrst.reg%0d", r), bus.valA, 64'd0);
        end
        wb_idle();
        rst_n = 1'b1;
        bus.wb_dstE = 4'h7;
        bus.wb_valE = 64'h1234_5678;
        tick();
        wb_idle();
        load(64'd30, 80'h6077_0000_0000_0000_0000);
        #1;
        check("postrst.write", bus.valA, 64'h1234_5678);
        check_all("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
